lfsr_descrambler: RTL and testbench
===================================

// Module: lfsr_descrambler
// PURPOSE
//  Receive-side additive descrambler; counterpart of the 8-bit LFSR scrambler on the TX path.
//  XORs each incoming byte with the keystream byte, recovering the plaintext.
//  Keystream restarts from SEED at every start-of-frame.
//  Sits between the link deserializer and the frame parser; valid/ready on both sides.
// PARAMETERS
//  WIDTH  8      data and LFSR width (only 8 supported; elaborates an error otherwise)
//  SEED   8'hFF  LFSR load value at start-of-frame; 0 is replaced by 8'h01
// PORTS
//  clk         in   1  sole clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  in_valid    in   1  input beat valid
//  in_ready    out  1  input beat accepted when in_valid & in_ready
//  in_data     in   8  scrambled byte
//  in_sof      in   1  beat is first byte of frame
//  in_last     in   1  beat is last byte of frame
//  out_valid   out  1  output beat valid
//  out_ready   in   1  downstream accepts
//  out_data    out  8  descrambled byte
//  out_sof     out  1  copy of in_sof for this beat
//  out_last    out  1  copy of in_last for this beat
//  drop_pulse  out  1  1-cycle pulse: beat accepted in IDLE without sof, discarded
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sof=0, out_last=0, drop_pulse=0, lfsr=SEED, state=IDLE.
//  - LFSR step: next = {s[6:0], s[5]^s[7]}; keystream byte = current s; one step per accepted beat.
//  - in_ready = !out_valid | out_ready (1-deep output register, full throughput, latency 1).
//  - FSM IDLE: beat w/o sof -> consumed, not forwarded, drop_pulse=1, lfsr unchanged.
//    Beat with sof -> out_data = in_data ^ SEED; lfsr <= step(SEED); go RUN (stay IDLE if in_last).
//  - FSM RUN: beat -> out_data = in_data ^ lfsr; lfsr <= step(lfsr).
//    sof in RUN: treated as new frame (reload from SEED as in IDLE); previous frame truncated.
//    in_last (incl. sof&last): after the beat, state <= IDLE, lfsr <= SEED.
//  - Backpressure: out_valid & !out_ready holds out_* stable; lfsr and state frozen.
//  - out_valid deasserts only after an accepted output with no new input beat.
//  - Reset mid-frame: all in-flight data lost; first frame after reset needs sof.
// CONFIGURATION
//  DESCR_BYPASS_EN defined: adds input port bypass (1 bit). When bypass=1 on an accepted
//    beat, out_data = in_data unmodified, lfsr not stepped; FSM and sof/last handling unchanged.
//    bypass sampled per beat; toggling mid-frame is legal.
//  DESCR_BYPASS_EN undefined: no bypass port; every beat in a frame is descrambled.
// STRUCTURE
//  - Package lfsr_scr_pkg: LFSR_W=8, TAP_HI=7, TAP_LO=5, state enum {ST_IDLE, ST_RUN},
//    function lfsr_step(s). Shared with the TX scrambler so both sides stay bit-identical.
//  - Sub-module lfsr_keystream: LFSR register with load (seed), advance, hold; key output = state.
//  - Top holds FSM, handshake and output register.
// TESTING
//  1. sof beat 8'h00 then 7x 8'h00, last on 8th -> out FF,FE,FC,F8,F0,E0,C0,81; last on 81.
//  2. sof&last beat 8'hA5 -> single out 8'h5A with out_sof=out_last=1; state back to IDLE.
//  3. after reset, 3 beats w/o sof -> 3 drop_pulse, no out_valid; then sof 8'hFF -> out 8'h00.
//  4. out_ready=0 for 5 cycles mid-frame -> out_* stable, in_ready=0, next bytes continue sequence.
//  5. sof in RUN after 3 bytes -> new frame restarts with key FF; earlier beats unaffected.
//  6. rst_n low mid-frame (async, between edges) -> out_valid=0 immediately; next beat needs sof.

Source files
------------

// File: rtl/lfsr_scr_pkg.sv
// Shared LFSR definitions for the TX scrambler and RX descrambler.
// Both sides use the same step function, so their keystreams stay bit-identical.
package lfsr_scr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned TAP_HI = 7;
    localparam int unsigned TAP_LO = 5;

    typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Keystream LFSR register. Supports load (seed), load-and-advance, advance and hold.
// SEED must be non-zero; the parent substitutes 8'h01 for zero.
module lfsr_keystream
    import lfsr_scr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_adv,
    output logic [LFSR_W-1:0] o_key
);

    logic [LFSR_W-1:0] r_lfsr;

    // load+adv means the current beat consumed the seed byte itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= i_adv ? lfsr_step(SEED) : SEED;
        end else if (i_adv) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_key = r_lfsr;

endmodule

// File: rtl/lfsr_descrambler.sv
// Receive-side additive descrambler with valid/ready on both sides and a 1-deep output register.
// Define DESCR_BYPASS_EN to add a per-beat bypass input that forwards data unscrambled.
module lfsr_descrambler
    import lfsr_scr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [7:0]  SEED  = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DESCR_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sof,
    output logic             out_last,
    output logic             drop_pulse
);

    if (WIDTH != LFSR_W) begin : g_width_check
        $error("lfsr_descrambler: only WIDTH=8 is supported");
    end

    // An all-zero LFSR would lock up, so a zero seed is replaced with 1
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 8'h01 : SEED;

    state_e            r_state;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_sof;
    logic              r_out_last;
    logic              r_drop;

    logic              w_bypass;
    logic              w_in_acc;
    logic              w_fwd;
    logic              w_drop;
    logic              w_load;
    logic              w_adv;
    logic [LFSR_W-1:0] w_ks_key;
    logic [LFSR_W-1:0] w_key;
    logic [WIDTH-1:0]  w_data;

`ifdef DESCR_BYPASS_EN
    assign w_bypass = bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready = ~r_out_valid | out_ready;
    assign w_in_acc = in_valid & in_ready;
    assign w_fwd    = w_in_acc & (in_sof | (r_state == ST_RUN));
    assign w_drop   = w_in_acc & ~in_sof & (r_state == ST_IDLE);

    // sof always restarts from the seed, even when it truncates a running frame
    assign w_key  = in_sof ? SEED_EFF : w_ks_key;
    assign w_data = w_bypass ? in_data : (in_data ^ w_key);
    assign w_load = w_fwd & (in_sof | in_last);
    assign w_adv  = w_fwd & ~w_bypass & ~in_last;

    lfsr_keystream #(
        .SEED (SEED_EFF)
    ) u_keystream (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_key  (w_ks_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sof   <= 1'b0;
            r_out_last  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_fwd) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sof   <= in_sof;
                r_out_last  <= in_last;
                r_state     <= in_last ? ST_IDLE : ST_RUN;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sof    = r_out_sof;
    assign out_last   = r_out_last;
    assign drop_pulse = r_drop;

endmodule

// File: tb/tb_lfsr_descrambler.sv
// Scoreboard testbench for lfsr_descrambler: a frame-level reference model pushes expected
// beats into a queue and a negedge monitor pops and compares every transferred output beat.
module tb_lfsr_descrambler;

    localparam logic [7:0] SEED = 8'hFF;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_last;
    logic       drop_pulse;
`ifdef DESCR_BYPASS_EN
    logic       bypass;
`endif

    int checks = 0;
    int failures = 0;
    int drops_seen = 0;
    int drops_exp = 0;
    logic force_stall = 1'b0;
    logic rdy_mode = 1'b0;

    // Reference model: frame-active flag and number of keystream bytes used in this frame
    logic m_run = 1'b0;
    int   m_idx = 0;
    logic [9:0] exp_q[$];

    lfsr_descrambler #(
        .WIDTH (8),
        .SEED  (SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DESCR_BYPASS_EN
        .bypass     (bypass),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_last   (out_last),
        .drop_pulse (drop_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keystream byte n of a frame: seed advanced n times with the feedback rule
    function automatic logic [7:0] key_at(input int n);
        logic [7:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5]};
        return s;
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic s, input logic l);
        if (!m_run && !s) begin
            drops_exp++;
        end else begin
            if (s) m_idx = 0;
            exp_q.push_back({s, l, d ^ key_at(m_idx)});
            if (l) begin
                m_run = 1'b0;
                m_idx = 0;
            end else begin
                m_run = 1'b1;
                m_idx++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [7:0] d, input logic s, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_sof = s;
        in_last = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, s, l);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        m_run = 1'b0;
        m_idx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (force_stall) out_ready = 1'b0;
            else if (rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Monitor: an output beat transfers at the posedge following a negedge with valid&ready
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop_pulse) drops_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {22'd0, out_sof, out_last, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("out_beat", {22'd0, out_sof, out_last, out_data},
                        {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [9:0] held;
        int base;
        int n;
        int len;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_sof = 1'b0;
        in_last = 1'b0;
`ifdef DESCR_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sof", 32'(out_sof), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_drop", 32'(drop_pulse), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Zero frame exposes the raw keystream FF,FE,FC,F8,F0,E0,C0,81
        send(8'h00, 1'b1, 1'b0);
        repeat (6) send(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1);

        // Single-beat frame; the following beat without sof must be dropped
        send(8'hA5, 1'b1, 1'b1);
        send(8'h33, 1'b0, 1'b0);

        // Fresh reset then orphan beats
        do_reset();
        base = drops_seen;
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom), 1'b0, 1'($urandom));
            @(negedge clk);
            chk("orphan_no_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("orphan_drops", 32'(drops_seen - base), 32'd3);
        send(8'hFF, 1'b1, 1'b1);

        // Backpressure mid-frame
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        force_stall = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h44;
        in_sof = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        held = {out_sof, out_last, out_data};
        chk("stall_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold", {22'd0, out_sof, out_last, out_data}, {22'd0, held});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        force_stall = 1'b0;
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1);

        // sof arriving in RUN truncates and restarts
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b1, 1'b0);
        send(8'h05, 1'b0, 1'b0);
        send(8'h06, 1'b0, 1'b1);

        // Asynchronous reset between edges while an output is pending
        send(8'h77, 1'b1, 1'b0);
        send(8'h88, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        m_run = 1'b0;
        m_idx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h99, 1'b0, 1'b0);
        send(8'h5C, 1'b1, 1'b1);

        // Randomized frames, junk beats, truncations and random backpressure
        rdy_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'b0, 1'($urandom));
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                send(8'($urandom), (b == 0) || ($urandom_range(0, 15) == 0), b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        chk("drop_total", 32'(drops_seen), 32'(drops_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
